decode_pipe: RTL and testbench

DECODE_PIPE -- requirements
Module: decode_pipe

---
 rtl/decode_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_decode_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_pipe.sv
// Decode stage of a MIPS-style pipeline: fetch holding register, register file
// with write-through, operand forwarding, hazard detection, branch/jump resolution.
module decode_pipe #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int FWD_N  = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_valid,
    output logic                    if_ready,
    input  logic [DATA_W-1:0]       if_pc4,
    input  logic [31:0]             if_instr,
    output logic                    ex_valid,
    input  logic                    ex_ready,
    output logic [DATA_W-1:0]       ex_rs_val,
    output logic [DATA_W-1:0]       ex_rt_val,
    output logic [DATA_W-1:0]       ex_imm,
    output logic [AW-1:0]           ex_rs,
    output logic [AW-1:0]           ex_rt,
    output logic [AW-1:0]           ex_rd,
    output logic [7:0]              ex_ctrl,
    output logic                    ex_syscall,
    input  logic                    wb_we,
    input  logic [AW-1:0]           wb_addr,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic [FWD_N-1:0]        fwd_valid,
    input  logic [FWD_N*AW-1:0]     fwd_addr,
    input  logic [FWD_N*DATA_W-1:0] fwd_data,
    output logic                    redirect,
    output logic [DATA_W-1:0]       redirect_pc,
    output logic [15:0]             stall_cnt
);
    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A, F_JR = 6'h08, F_SYS = 6'h0C;

    logic [31:0]       d_instr_r;
    logic [DATA_W-1:0] d_pc4_r;
    logic              d_valid_r;
    logic [DATA_W-1:0] rf_r [NREG];

    logic              ex_valid_r, ex_syscall_r;
    logic [DATA_W-1:0] ex_rs_val_r, ex_rt_val_r, ex_imm_r;
    logic [AW-1:0]     ex_rs_r, ex_rt_r, ex_rd_r;
    logic [7:0]        ex_ctrl_r;
    logic [15:0]       stall_cnt_r;

    logic [5:0]        op_s, funct_s;
    logic [AW-1:0]     rs_s, rt_s, rd_s, ex_dest_s;
    logic [DATA_W-1:0] imm_s, rs_val_s, rt_val_s, target_s, br_tgt_s, j_tgt_s;
    logic [7:0]        ctrl_s;
    logic              syscall_s, uses_rs_s, uses_rt_s, is_br_s, br_cmp_rt_s;
    logic              taken_s, is_jal_s, load_use_s, br_haz_s, hazard_s;
    logic              d_advance_s, redirect_s, if_ready_s;
    logic              unused_shamt_s;

    assign op_s     = d_instr_r[31:26];
    assign rs_s     = AW'(d_instr_r[25:21]);
    assign rt_s     = AW'(d_instr_r[20:16]);
    assign rd_s     = AW'(d_instr_r[15:11]);
    assign funct_s  = d_instr_r[5:0];
    assign imm_s    = {{(DATA_W-16){d_instr_r[15]}}, d_instr_r[15:0]};
    assign br_tgt_s = d_pc4_r + {imm_s[DATA_W-3:0], 2'b00};
    assign j_tgt_s  = {d_pc4_r[DATA_W-1:28], d_instr_r[25:0], 2'b00};
    assign unused_shamt_s = ^d_instr_r[10:6];

    // Operand select: lowest-index forward wins, then write-through, then register file
    always_comb begin
        rs_val_s = (wb_we && wb_addr == rs_s) ? wb_data : rf_r[rs_s];
        rt_val_s = (wb_we && wb_addr == rt_s) ? wb_data : rf_r[rt_s];
        for (int i = FWD_N - 1; i >= 0; i--) begin
            rs_val_s = (fwd_valid[i] && fwd_addr[i*AW +: AW] == rs_s) ? fwd_data[i*DATA_W +: DATA_W] : rs_val_s;
            rt_val_s = (fwd_valid[i] && fwd_addr[i*AW +: AW] == rt_s) ? fwd_data[i*DATA_W +: DATA_W] : rt_val_s;
        end
        rs_val_s = (rs_s == {AW{1'b0}}) ? {DATA_W{1'b0}} : rs_val_s;
        rt_val_s = (rt_s == {AW{1'b0}}) ? {DATA_W{1'b0}} : rt_val_s;
    end

    // Instruction decode and branch/jump resolution
    always_comb begin
        ctrl_s      = 8'd0;
        syscall_s   = 1'b0;
        uses_rs_s   = 1'b0;
        uses_rt_s   = 1'b0;
        is_br_s     = 1'b0;
        br_cmp_rt_s = 1'b0;
        taken_s     = 1'b0;
        is_jal_s    = 1'b0;
        target_s    = br_tgt_s;
        case (op_s)
            OP_R: begin
                uses_rs_s = 1'b1;
                uses_rt_s = 1'b1;
                case (funct_s)
                    F_ADD:   ctrl_s = 8'b1000_1010;
                    F_SUB:   ctrl_s = 8'b1000_1110;
                    F_AND:   ctrl_s = 8'b1000_1000;
                    F_OR:    ctrl_s = 8'b1000_1001;
                    F_SLT:   ctrl_s = 8'b1000_1111;
                    F_JR: begin
                        is_br_s  = 1'b1;
                        taken_s  = 1'b1;
                        target_s = rs_val_s;
                    end
                    F_SYS:   syscall_s = 1'b1;
                    default: ctrl_s = 8'd0;
                endcase
            end
            OP_ADDI: begin
                uses_rs_s = 1'b1;
                ctrl_s    = 8'b1001_0010;
            end
            OP_LW: begin
                uses_rs_s = 1'b1;
                ctrl_s    = 8'b1101_0010;
            end
            OP_SW: begin
                uses_rs_s = 1'b1;
                uses_rt_s = 1'b1;
                ctrl_s    = 8'b0011_0010;
            end
            OP_BEQ, OP_BNE: begin
                uses_rs_s   = 1'b1;
                uses_rt_s   = 1'b1;
                is_br_s     = 1'b1;
                br_cmp_rt_s = 1'b1;
                taken_s     = (rs_val_s == rt_val_s) ^ (op_s == OP_BNE);
            end
            OP_J: begin
                taken_s  = 1'b1;
                target_s = j_tgt_s;
            end
            OP_JAL: begin
                taken_s  = 1'b1;
                target_s = j_tgt_s;
                is_jal_s = 1'b1;
                ctrl_s   = 8'b1001_0010;
            end
            default: ctrl_s = 8'd0;
        endcase
    end

    assign ex_dest_s  = ex_ctrl_r[3] ? ex_rd_r : ex_rt_r;
    assign load_use_s = ex_valid_r && ex_ctrl_r[6] && (ex_rt_r != {AW{1'b0}}) &&
                        ((uses_rs_s && ex_rt_r == rs_s) || (uses_rt_s && ex_rt_r == rt_s));
    assign br_haz_s   = is_br_s && ex_valid_r && ex_ctrl_r[7] && (ex_dest_s != {AW{1'b0}}) &&
                        ((ex_dest_s == rs_s) || (br_cmp_rt_s && ex_dest_s == rt_s));
    assign hazard_s    = d_valid_r && (load_use_s || br_haz_s);
    assign d_advance_s = d_valid_r && !hazard_s && (!ex_valid_r || ex_ready);
    assign redirect_s  = d_advance_s && taken_s;
    assign if_ready_s  = !d_valid_r || d_advance_s;

    // Fetch holding register; a fetch landing in a redirect cycle is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_valid_r <= 1'b0;
            d_instr_r <= 32'd0;
            d_pc4_r   <= {DATA_W{1'b0}};
        end else if (if_valid && if_ready_s && !redirect_s) begin
            d_valid_r <= 1'b1;
            d_instr_r <= if_instr;
            d_pc4_r   <= if_pc4;
        end else if (d_advance_s) begin
            d_valid_r <= 1'b0;
        end
    end

    // ID/EX slot: load decoded instruction, insert bubble, or hold under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_r   <= 1'b0;
            ex_syscall_r <= 1'b0;
            ex_ctrl_r    <= 8'd0;
            ex_rs_val_r  <= {DATA_W{1'b0}};
            ex_rt_val_r  <= {DATA_W{1'b0}};
            ex_imm_r     <= {DATA_W{1'b0}};
            ex_rs_r      <= {AW{1'b0}};
            ex_rt_r      <= {AW{1'b0}};
            ex_rd_r      <= {AW{1'b0}};
        end else if (d_advance_s) begin
            ex_valid_r   <= 1'b1;
            ex_syscall_r <= syscall_s;
            ex_ctrl_r    <= ctrl_s;
            ex_rs_val_r  <= is_jal_s ? d_pc4_r : rs_val_s;
            ex_rt_val_r  <= rt_val_s;
            ex_imm_r     <= is_jal_s ? {DATA_W{1'b0}} : imm_s;
            ex_rs_r      <= is_jal_s ? {AW{1'b0}} : rs_s;
            ex_rt_r      <= is_jal_s ? AW'(5'd31) : rt_s;
            ex_rd_r      <= is_jal_s ? AW'(5'd31) : rd_s;
        end else if (ex_ready || !ex_valid_r) begin
            ex_valid_r   <= 1'b0;
            ex_syscall_r <= 1'b0;
            ex_ctrl_r    <= 8'd0;
            ex_rs_val_r  <= {DATA_W{1'b0}};
            ex_rt_val_r  <= {DATA_W{1'b0}};
            ex_imm_r     <= {DATA_W{1'b0}};
            ex_rs_r      <= {AW{1'b0}};
            ex_rt_r      <= {AW{1'b0}};
            ex_rd_r      <= {AW{1'b0}};
        end
    end

    // Register file; register 0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf_r[i] <= {DATA_W{1'b0}};
        end else if (wb_we && wb_addr != {AW{1'b0}}) begin
            rf_r[wb_addr] <= wb_data;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if (hazard_s && stall_cnt_r != 16'hFFFF) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign if_ready    = if_ready_s;
    assign ex_valid    = ex_valid_r;
    assign ex_syscall  = ex_syscall_r;
    assign ex_ctrl     = ex_ctrl_r;
    assign ex_rs_val   = ex_rs_val_r;
    assign ex_rt_val   = ex_rt_val_r;
    assign ex_imm      = ex_imm_r;
    assign ex_rs       = ex_rs_r;
    assign ex_rt       = ex_rt_r;
    assign ex_rd       = ex_rd_r;
    assign redirect    = redirect_s;
    assign redirect_pc = target_s;
    assign stall_cnt   = stall_cnt_r;
endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: forwarding, hazards, redirects, backpressure, reset.
module tb_decode_pipe;
    logic        clk = 1'b0;
    logic        rst_n, if_valid, if_ready, ex_valid, ex_ready, ex_syscall;
    logic        wb_we, redirect;
    logic [31:0] if_pc4, if_instr, ex_rs_val, ex_rt_val, ex_imm, wb_data, redirect_pc;
    logic [4:0]  ex_rs, ex_rt, ex_rd, wb_addr;
    logic [7:0]  ex_ctrl;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic [15:0] stall_cnt;
    int total = 0;
    int bad = 0;

    decode_pipe dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
        .if_pc4(if_pc4), .if_instr(if_instr), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .ex_syscall(ex_syscall), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One fetch handshake; returns in the cycle the word sits in D
    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc);
        if_valid = 1'b1; if_instr = ins; if_pc4 = pc;
        @(posedge clk); #1;
        if_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL rst_ex_valid got=%0h exp=0", ex_valid); end
        total++; if (ex_ctrl !== 8'h00) begin bad++; $display("FAIL rst_ex_ctrl got=%0h exp=0", ex_ctrl); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall_cnt); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL rst_redirect got=%0h exp=0", redirect); end
        rst_n = 1'b1;
        idle(1);
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL rst_if_ready got=%0h exp=1", if_ready); end
    endtask

    task automatic test_basic();
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'd7;
        fetch(r_op(5'd5, 5'd5, 5'd3, 6'h20), 32'h4);
        wb_we = 1'b0;
        idle(1);
        total++; if (ex_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0h exp=1", ex_valid); end
        total++; if (ex_rs_val !== 32'd7) begin bad++; $display("FAIL basic_rs_val got=%0h exp=7", ex_rs_val); end
        total++; if (ex_rt_val !== 32'd7) begin bad++; $display("FAIL basic_rt_val got=%0h exp=7", ex_rt_val); end
        total++; if (ex_ctrl !== 8'b1000_1010) begin bad++; $display("FAIL basic_ctrl got=%0h exp=8a", ex_ctrl); end
        total++; if (ex_rd !== 5'd3) begin bad++; $display("FAIL basic_rd got=%0d exp=3", ex_rd); end
    endtask

    task automatic test_write_through();
        idle(2);
        fetch(r_op(5'd8, 5'd8, 5'd13, 6'h22), 32'h8);
        wb_we = 1'b1; wb_addr = 5'd8; wb_data = 32'h55;
        idle(1);
        wb_we = 1'b0;
        total++; if (ex_rs_val !== 32'h55) begin bad++; $display("FAIL wt_rs_val got=%0h exp=55", ex_rs_val); end
        total++; if (ex_ctrl !== 8'b1000_1110) begin bad++; $display("FAIL wt_sub_ctrl got=%0h exp=8e", ex_ctrl); end
    endtask

    task automatic test_load_use();
        idle(2);
        fetch(i_op(6'h23, 5'd1, 5'd2, 16'h0000), 32'h10);
        fetch(r_op(5'd2, 5'd2, 5'd4, 6'h20), 32'h14);
        total++; if (ex_ctrl !== 8'b1101_0010) begin bad++; $display("FAIL lu_lw_ctrl got=%0h exp=d2", ex_ctrl); end
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL lu_stall_ready got=%0h exp=0", if_ready); end
        idle(1);
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble got=%0h exp=0", ex_valid); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        idle(1);
        total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd4) begin bad++; $display("FAIL lu_add_issue got=%0h/%0d exp=1/4", ex_valid, ex_rd); end
        total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_hold got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_branch();
        idle(2);
        fetch(i_op(6'h04, 5'd1, 5'd1, 16'd3), 32'h100);
        if_valid = 1'b1; if_instr = r_op(5'd1, 5'd1, 5'd9, 6'h20); if_pc4 = 32'h104;
        #1;
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL beq_redirect got=%0h exp=1", redirect); end
        total++; if (redirect_pc !== 32'h10C) begin bad++; $display("FAIL beq_target got=%0h exp=10c", redirect_pc); end
        idle(1);
        if_valid = 1'b0;
        total++; if (ex_valid !== 1'b1 || ex_ctrl !== 8'h00) begin bad++; $display("FAIL beq_nop got=%0h/%0h exp=1/0", ex_valid, ex_ctrl); end
        idle(1);
        total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL beq_discard got=%0h exp=0", ex_valid); end
        fetch(i_op(6'h05, 5'd1, 5'd1, 16'd3), 32'h200);
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL bne_not_taken got=%0h exp=0", redirect); end
    endtask

    task automatic test_forward();
        idle(2);
        fetch(r_op(5'd6, 5'd0, 5'd10, 6'h25), 32'h20);
        fwd_valid = 2'b11; fwd_addr = {5'd6, 5'd6}; fwd_data = {32'hBB, 32'hAA};
        wb_we = 1'b1; wb_addr = 5'd6; wb_data = 32'hCC;
        idle(1);
        wb_we = 1'b0; fwd_valid = 2'b10;
        total++; if (ex_rs_val !== 32'hAA) begin bad++; $display("FAIL fwd_prio got=%0h exp=aa", ex_rs_val); end
        total++; if (ex_rt_val !== 32'h0) begin bad++; $display("FAIL fwd_r0_rt got=%0h exp=0", ex_rt_val); end
        fetch(r_op(5'd6, 5'd6, 5'd10, 6'h24), 32'h24);
        idle(1);
        fwd_valid = 2'b00;
        total++; if (ex_rs_val !== 32'hBB) begin bad++; $display("FAIL fwd_src1 got=%0h exp=bb", ex_rs_val); end
        fetch(r_op(5'd6, 5'd0, 5'd10, 6'h2A), 32'h28);
        idle(1);
        total++; if (ex_rs_val !== 32'hCC) begin bad++; $display("FAIL rf_read got=%0h exp=cc", ex_rs_val); end
        total++; if (ex_ctrl !== 8'b1000_1111) begin bad++; $display("FAIL slt_ctrl got=%0h exp=8f", ex_ctrl); end
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
        fwd_valid = 2'b01; fwd_addr = {5'd6, 5'd0}; fwd_data = {32'hBB, 32'hDD};
        fetch(r_op(5'd0, 5'd0, 5'd0, 6'h20), 32'h2C);
        idle(1);
        wb_we = 1'b0; fwd_valid = 2'b00;
        total++; if (ex_rs_val !== 32'h0 || ex_rt_val !== 32'h0) begin bad++; $display("FAIL r0_reads_zero got=%0h/%0h exp=0/0", ex_rs_val, ex_rt_val); end
    endtask

    task automatic test_jal_hold();
        idle(2);
        fetch({6'h03, 26'h40}, 32'h200);
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin bad++; $display("FAIL jal_redirect got=%0h/%0h exp=1/100", redirect, redirect_pc); end
        ex_ready = 1'b0;
        idle(1);
        total++; if (ex_ctrl !== 8'b1001_0010 || ex_rd !== 5'd31) begin bad++; $display("FAIL jal_issue got=%0h/%0d exp=92/31", ex_ctrl, ex_rd); end
        total++; if (ex_rs_val !== 32'h200 || ex_imm !== 32'h0) begin bad++; $display("FAIL jal_vals got=%0h/%0h exp=200/0", ex_rs_val, ex_imm); end
        fetch(r_op(5'd1, 5'd1, 5'd12, 6'h20), 32'h104);
        for (int c = 0; c < 3; c++) begin
            total++; if (if_ready !== 1'b0 || ex_valid !== 1'b1) begin bad++; $display("FAIL hold_ready c=%0d got=%0h/%0h exp=0/1", c, if_ready, ex_valid); end
            total++; if (ex_rd !== 5'd31 || ex_rs_val !== 32'h200 || ex_ctrl !== 8'h92) begin bad++; $display("FAIL hold_stable c=%0d got=%0d/%0h/%0h", c, ex_rd, ex_rs_val, ex_ctrl); end
            idle(1);
        end
        ex_ready = 1'b1;
        idle(1);
        total++; if (ex_rd !== 5'd12 || ex_ctrl !== 8'h8A) begin bad++; $display("FAIL hold_release got=%0d/%0h exp=12/8a", ex_rd, ex_ctrl); end
    endtask

    task automatic test_branch_hazard();
        idle(2);
        fetch(i_op(6'h08, 5'd0, 5'd7, 16'd5), 32'h2FC);
        fetch(i_op(6'h04, 5'd7, 5'd0, 16'd1), 32'h300);
        total++; if (redirect !== 1'b0 || if_ready !== 1'b0) begin bad++; $display("FAIL bh_stall got=%0h/%0h exp=0/0", redirect, if_ready); end
        total++; if (ex_imm !== 32'd5 || ex_rt !== 5'd7) begin bad++; $display("FAIL addi_fields got=%0h/%0d exp=5/7", ex_imm, ex_rt); end
        idle(1);
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL bh_stall_cnt got=%0d exp=2", stall_cnt); end
        total++; if (redirect !== 1'b1 || redirect_pc !== 32'h304) begin bad++; $display("FAIL bh_resolve got=%0h/%0h exp=1/304", redirect, redirect_pc); end
    endtask

    task automatic test_misc();
        idle(2);
        fetch({6'h3F, 26'h0}, 32'h400);
        idle(1);
        total++; if (ex_valid !== 1'b1 || ex_ctrl !== 8'h00) begin bad++; $display("FAIL illegal_nop got=%0h/%0h exp=1/0", ex_valid, ex_ctrl); end
        fetch(r_op(5'd0, 5'd0, 5'd0, 6'h0C), 32'h404);
        idle(1);
        total++; if (ex_syscall !== 1'b1 || ex_ctrl !== 8'h00) begin bad++; $display("FAIL syscall got=%0h/%0h exp=1/0", ex_syscall, ex_ctrl); end
        fetch(i_op(6'h2B, 5'd1, 5'd2, 16'hFFFC), 32'h408);
        idle(1);
        total++; if (ex_ctrl !== 8'b0011_0010 || ex_imm !== 32'hFFFF_FFFC) begin bad++; $display("FAIL sw_decode got=%0h/%0h exp=32/fffffffc", ex_ctrl, ex_imm); end
    endtask

    task automatic test_reset_mid();
        idle(2);
        fetch(i_op(6'h23, 5'd1, 5'd2, 16'h0000), 32'h500);
        fetch(r_op(5'd2, 5'd2, 5'd4, 6'h20), 32'h504);
        rst_n = 1'b0;
        #1;
        total++; if (ex_valid !== 1'b0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL mid_rst_clear got=%0h/%0d exp=0/0", ex_valid, stall_cnt); end
        idle(1);
        rst_n = 1'b1;
        idle(1);
        total++; if (if_ready !== 1'b1 || ex_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_release got=%0h/%0h exp=1/0", if_ready, ex_valid); end
        fetch(r_op(5'd5, 5'd6, 5'd3, 6'h20), 32'h4);
        idle(1);
        total++; if (ex_rs_val !== 32'h0 || ex_rt_val !== 32'h0) begin bad++; $display("FAIL rf_cleared got=%0h/%0h exp=0/0", ex_rs_val, ex_rt_val); end
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_pc4 = 32'h0; if_instr = 32'h0; ex_ready = 1'b1;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        fwd_valid = 2'b00; fwd_addr = 10'd0; fwd_data = 64'd0;
        idle(2);
        test_reset();
        test_basic();
        test_write_through();
        test_load_use();
        test_branch();
        test_forward();
        test_jal_hold();
        test_branch_hazard();
        test_misc();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
